// File: rtl/seg_arb_pkg.sv
// Shared constants and types for the 7-segment display arbiter.
// SEGARB_BLANK_GAP_EN adds the GAP state (one blank scan between owners).
package seg_arb_pkg;

  localparam int DIGIT_W = 7;
  localparam int FRAME_W = 28;

  localparam logic [DIGIT_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;

  // Four digits, digit 3 (leftmost) in the top slice.
  typedef logic [3:0][DIGIT_W-1:0] frame_t;

  localparam frame_t BLANK_FRAME = {4{SEG_BLANK}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef SEGARB_BLANK_GAP_EN
    ST_GAP  = 2'd2,
`endif
    ST_OWN  = 2'd1
  } arb_state_t;

  // Active-low anode pattern for a digit index.
  function automatic logic [3:0] an_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    an_sel = AN_DIG0;
      2'd1:    an_sel = AN_DIG1;
      2'd2:    an_sel = AN_DIG2;
      default: an_sel = AN_DIG3;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit-slot divider and scan position. A tick fires when the divider wraps;
// the tick that moves the digit index from 3 to 0 is a scan boundary.
module seg_scan_timer #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  output logic       tick,
  output logic       boundary,
  output logic [1:0] idx_next,
  output logic       scan_done
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;

  assign tick     = (div == DIV_W'(REFRESH_DIV - 1));
  assign idx_next = idx + 2'd1;
  assign boundary = tick && (idx == 2'd3);

  // Divider, digit index and the registered scan-start pulse.
  // idx resets to 3 so the very first tick is a scan boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      div       <= '0;
      idx       <= 2'd3;
      scan_done <= 1'b0;
    end else begin
      scan_done <= boundary;
      if (tick) begin
        div <= '0;
        idx <= idx_next;
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares one 4-digit 7-segment display among N_REQ requesters.
// Ownership changes only on scan boundaries (round-robin, bounded hold), and
// the owner's frame is snapshotted there so a scan never tears.
// Optional: SEGARB_BLANK_GAP_EN inserts one blank scan between two owners.
module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int REFRESH_DIV = 50000,
  parameter int MAX_HOLD    = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [FRAME_W*N_REQ-1:0]   frame,
  output logic [N_REQ-1:0]           grant,
  output logic [3:0]                 an,
  output logic [DIGIT_W-1:0]         out,
  output logic                       scan_done
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef logic [IDX_W-1:0] rid_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic        tick, boundary;
  logic [1:0]  idx_next;

  arb_state_t  state, state_nxt;
  rid_t        owner, owner_nxt;
  rid_t        rr_ptr, rr_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  frame_t      snap, snap_nxt;
  logic [N_REQ-1:0]  grant_nxt;

  frame_t [N_REQ-1:0] frames;
  assign frames = frame;

  seg_scan_timer #(.REFRESH_DIV(REFRESH_DIV)) u_timer (
    .clock     (clock),
    .reset     (reset),
    .tick      (tick),
    .boundary  (boundary),
    .idx_next  (idx_next),
    .scan_done (scan_done)
  );

  // Round-robin search: first high req after the base, wrapping. While an
  // owner holds the display the base is the owner, otherwise the pointer.
  rid_t  base, pick;
  logic  found;
  always_comb begin
    int c;
    c     = 0;
    base  = (state == ST_OWN) ? owner : rr_ptr;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      c = int'(base) + 1 + k;
      if (c >= N_REQ) c = c - N_REQ;
      if (!found && req[rid_t'(c)]) begin
        found = 1'b1;
        pick  = rid_t'(c);
      end
    end
  end

  // Owner keeps the display if still requesting and either uncontested or
  // still inside its hold budget.
  logic others, keep;
  always_comb begin
    others = |(req & ~(N_REQ'(1) << owner));
    keep   = req[owner] && (!others || (hold_cnt < HOLD_LAST));
  end

  // Arbiter next-state: decisions are taken only on scan boundaries.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    hold_nxt  = hold_cnt;
    snap_nxt  = snap;
    if (boundary) begin
      case (state)
        ST_OWN: begin
          if (keep) begin
            snap_nxt = frames[owner];
            if (hold_cnt != HOLD_LAST) hold_nxt = hold_cnt + HOLD_W'(1);
          end else if (found) begin
`ifdef SEGARB_BLANK_GAP_EN
            // rr_ptr already names the departing owner, so the next
            // boundary resumes the rotation just after it.
            state_nxt = ST_GAP;
            snap_nxt  = BLANK_FRAME;
`else
            state_nxt = ST_OWN;
            owner_nxt = pick;
            rr_nxt    = pick;
            hold_nxt  = '0;
            snap_nxt  = frames[pick];
`endif
          end else begin
            state_nxt = ST_IDLE;
            snap_nxt  = BLANK_FRAME;
          end
        end
        default: begin
          // IDLE and GAP both search from the pointer and never gap.
          if (found) begin
            state_nxt = ST_OWN;
            owner_nxt = pick;
            rr_nxt    = pick;
            hold_nxt  = '0;
            snap_nxt  = frames[pick];
          end else begin
            state_nxt = ST_IDLE;
            snap_nxt  = BLANK_FRAME;
          end
        end
      endcase
    end
  end

  assign grant_nxt = (state_nxt == ST_OWN) ? (N_REQ'(1) << owner_nxt) : '0;

  // Arbiter state, pointer, hold counter and frame snapshot.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      owner    <= '0;
      rr_ptr   <= rid_t'(N_REQ - 1);
      hold_cnt <= '0;
      snap     <= BLANK_FRAME;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_nxt;
      hold_cnt <= hold_nxt;
      snap     <= snap_nxt;
    end
  end

  // Registered outputs: the digit mux reads the next snapshot so a new
  // owner's digit 0 appears in the same cycle its grant does.
  always_ff @(posedge clock) begin
    if (reset) begin
      an    <= 4'b1111;
      out   <= SEG_BLANK;
      grant <= '0;
    end else if (tick) begin
      an  <= an_sel(idx_next);
      out <= snap_nxt[idx_next];
      if (boundary) grant <= grant_nxt;
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Randomized bench for seg_display_arbiter against a scan-level reference
// model. Honors SEGARB_BLANK_GAP_EN when defined at compile time.
module tb_seg_display_arbiter;

  localparam int N  = 3;
  localparam int RD = 2;
  localparam int MH = 2;
`ifdef SEGARB_BLANK_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [28*N-1:0] frame;
  logic [N-1:0]    grant;
  logic [3:0]      an;
  logic [6:0]      out;
  logic            scan_done;

  seg_display_arbiter #(.N_REQ(N), .REFRESH_DIV(RD), .MAX_HOLD(MH)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .frame     (frame),
    .grant     (grant),
    .an        (an),
    .out       (out),
    .scan_done (scan_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: elapsed cycles since reset, owner (-1 = none), last-owner
  // pointer, scans held, and the 4-digit picture being shown.
  int          m_cyc, m_owner, m_ptr, m_hold;
  logic [27:0] m_snap;
  logic [3:0]  m_an;
  logic [6:0]  m_out;
  logic        m_sd;

  function automatic int rr_find(input int base, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(base + k) % N]) return (base + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_owner = -1; m_ptr = N - 1; m_hold = 0;
    m_snap = '1; m_an = 4'hF; m_out = 7'h7F; m_sd = 1'b0;
  endtask

  task automatic arbitrate();
    int  f;
    bit  contested;
    if (m_owner >= 0) begin
      contested = (req & ~(N'(1) << m_owner)) != 0;
      if (req[m_owner] && (!contested || m_hold < MH - 1)) begin
        m_hold++;
        m_snap = frame[28*m_owner +: 28];
        return;
      end
      f = rr_find(m_owner, req);
      m_ptr = m_owner;
      if (f >= 0 && GAP_EN) begin
        m_owner = -1;
        m_snap  = '1;
        return;
      end
    end else begin
      f = rr_find(m_ptr, req);
    end
    if (f >= 0) begin
      m_owner = f; m_ptr = f; m_hold = 0;
      m_snap  = frame[28*f +: 28];
    end else begin
      m_owner = -1;
      m_snap  = '1;
    end
  endtask

  task automatic model_step();
    int nidx;
    if (reset) begin
      model_reset();
    end else begin
      m_cyc++;
      m_sd = 1'b0;
      if (m_cyc % RD == 0) begin
        nidx = (3 + m_cyc / RD) % 4;
        if (nidx == 0) begin
          arbitrate();
          m_sd = 1'b1;
        end
        m_out = m_snap[7*nidx +: 7];
        m_an  = 4'hF & ~(4'b1 << nidx);
      end
    end
  endtask

  // One clock: model consumes the inputs the DUT sees at this edge, then
  // outputs are compared 1 time unit later.
  task automatic step();
    logic [N-1:0] g;
    model_step();
    @(posedge clock);
    #1;
    g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    chk("an", 32'(an), 32'(m_an));
    chk("out", 32'(out), 32'(m_out));
    chk("grant", 32'(grant), 32'(g));
    chk("scan_done", 32'(scan_done), 32'(m_sd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [28*N-1:0] rand_frames();
    logic [28*N-1:0] v;
    for (int i = 0; i < N; i++) v[28*i +: 28] = 28'($urandom);
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    req   = '0;
    frame = rand_frames();
    run(3);
    reset = 1'b0;

    // idle, then a single requester, then two-way rotation
    run(20);
    req = 3'b001; run(24);
    req = 3'b011; run(48);
    // owner drops mid-scan
    req = 3'b001; run(5);
    req = 3'b000; run(16);

    // mid-scan reset while everyone requests
    req = 3'b111; run(5);
    reset = 1'b1; run(1);
    reset = 1'b0; run(30);

    // randomized traffic with frame churn and occasional resets
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 9) == 0) req = N'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) frame = rand_frames();
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    run(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
